// File: rtl/reservation_station.sv
// Four-entry reservation station: tag-tracked operand capture from the CDB,
// lowest-index issue/dispatch, and completion-driven entry release.
//
// state | meaning
// FREE  | slot unallocated, available for issue
// WAIT  | allocated, at least one operand tag still pending
// READY | both operands valid, eligible for dispatch
// EXEC  | handed to the functional unit, awaiting CDB completion
module reservation_station #(
    parameter bit UNIT    = 1'b0,
    parameter int ENTRIES = 4
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [23:0] cdb,
    input  logic        issue_valid,
    output logic        issue_ready,
    output logic [1:0]  issue_label,
    input  logic        issue_op,
    input  logic [2:0]  issue_rd,
    input  logic [3:0]  issue_qj,
    input  logic [3:0]  issue_qk,
    input  logic [15:0] issue_vj,
    input  logic [15:0] issue_vk,
    output logic        fu_valid,
    input  logic        fu_ready,
    output logic        fu_op,
    output logic [15:0] fu_a,
    output logic [15:0] fu_b,
    output logic [1:0]  fu_label,
    output logic [2:0]  fu_rd,
    output logic [3:0]  busy
);

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2,
        EXEC  = 2'd3
    } entryState_t;

    entryState_t state [ENTRIES];
    entryState_t stateNext [ENTRIES];
    logic        opR [ENTRIES];
    logic        opNext [ENTRIES];
    logic [2:0]  rdR [ENTRIES];
    logic [2:0]  rdNext [ENTRIES];
    logic [3:0]  qjR [ENTRIES];
    logic [3:0]  qjNext [ENTRIES];
    logic [3:0]  qkR [ENTRIES];
    logic [3:0]  qkNext [ENTRIES];
    logic [15:0] vjR [ENTRIES];
    logic [15:0] vjNext [ENTRIES];
    logic [15:0] vkR [ENTRIES];
    logic [15:0] vkNext [ENTRIES];

    logic        lockValid;
    logic [1:0]  lockIdx;
    logic        anyReady;
    logic [1:0]  readyIdx;
    logic [1:0]  dispIdx;

    logic        cdbValid;
    logic [2:0]  cdbTag;
    logic [15:0] cdbData;
    logic        unusedCdbBit;

    logic        issueFire;
    logic        issQjPend;
    logic        issQkPend;
    logic [15:0] issVj;
    logic [15:0] issVk;

    assign cdbValid     = cdb[22];
    assign cdbTag       = cdb[21:19];
    assign cdbData      = cdb[15:0];
    assign unusedCdbBit = cdb[23];

    always_comb begin
        issue_ready = 1'b0;
        issue_label = 2'd0;
        busy        = 4'd0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            busy[i] = (state[i] != FREE);
            if (state[i] == FREE) begin
                issue_ready = 1'b1;
                issue_label = 2'(i);
            end
        end
    end

    // A presented-but-unaccepted entry stays selected so fu_* cannot shift
    // under the functional unit when a lower entry turns READY.
    always_comb begin
        anyReady = 1'b0;
        readyIdx = 2'd0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (state[i] == READY) begin
                anyReady = 1'b1;
                readyIdx = 2'(i);
            end
        end
        dispIdx  = lockValid ? lockIdx : readyIdx;
        fu_valid = lockValid | anyReady;
        fu_op    = fu_valid ? opR[dispIdx] : 1'b0;
        fu_a     = fu_valid ? vjR[dispIdx] : 16'd0;
        fu_b     = fu_valid ? vkR[dispIdx] : 16'd0;
        fu_label = fu_valid ? dispIdx : 2'd0;
        fu_rd    = fu_valid ? rdR[dispIdx] : 3'd0;
    end

    always_comb begin
        issueFire = issue_valid & issue_ready;
        issQjPend = issue_qj[3] & ~(cdbValid & (issue_qj[2:0] == cdbTag));
        issQkPend = issue_qk[3] & ~(cdbValid & (issue_qk[2:0] == cdbTag));
        issVj     = issue_qj[3] ? (issQjPend ? 16'd0 : cdbData) : issue_vj;
        issVk     = issue_qk[3] ? (issQkPend ? 16'd0 : cdbData) : issue_vk;
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            stateNext[i] = state[i];
            opNext[i]    = opR[i];
            rdNext[i]    = rdR[i];
            qjNext[i]    = qjR[i];
            qkNext[i]    = qkR[i];
            vjNext[i]    = vjR[i];
            vkNext[i]    = vkR[i];
            case (state[i])
                FREE: begin
                    if (issueFire && issue_label == 2'(i)) begin
                        opNext[i]    = issue_op;
                        rdNext[i]    = issue_rd;
                        qjNext[i]    = {issQjPend, issue_qj[2:0]};
                        qkNext[i]    = {issQkPend, issue_qk[2:0]};
                        vjNext[i]    = issVj;
                        vkNext[i]    = issVk;
                        stateNext[i] = (issQjPend || issQkPend) ? WAIT : READY;
                    end
                end
                WAIT: begin
                    if (cdbValid && qjR[i][3] && qjR[i][2:0] == cdbTag) begin
                        vjNext[i]    = cdbData;
                        qjNext[i][3] = 1'b0;
                    end
                    if (cdbValid && qkR[i][3] && qkR[i][2:0] == cdbTag) begin
                        vkNext[i]    = cdbData;
                        qkNext[i][3] = 1'b0;
                    end
                    if (!qjNext[i][3] && !qkNext[i][3]) begin
                        stateNext[i] = READY;
                    end
                end
                READY: begin
                    if (fu_valid && fu_ready && dispIdx == 2'(i)) begin
                        stateNext[i] = EXEC;
                    end
                end
                EXEC: begin
                    if (cdbValid && cdb[21] == UNIT && cdb[20:19] == 2'(i)) begin
                        stateNext[i] = FREE;
                    end
                end
                default: stateNext[i] = state[i];
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                state[i] <= FREE;
                opR[i]   <= 1'b0;
                rdR[i]   <= 3'd0;
                qjR[i]   <= 4'd0;
                qkR[i]   <= 4'd0;
                vjR[i]   <= 16'd0;
                vkR[i]   <= 16'd0;
            end
            lockValid <= 1'b0;
            lockIdx   <= 2'd0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                state[i] <= stateNext[i];
                opR[i]   <= opNext[i];
                rdR[i]   <= rdNext[i];
                qjR[i]   <= qjNext[i];
                qkR[i]   <= qkNext[i];
                vjR[i]   <= vjNext[i];
                vkR[i]   <= vkNext[i];
            end
            lockValid <= fu_valid & ~fu_ready;
            lockIdx   <= dispIdx;
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station (UNIT=0): issue, bypass, snoop,
// dispatch hold, completion release and reset discard.
module tb_reservation_station;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [23:0] cdb;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  issue_label;
    logic        issue_op;
    logic [2:0]  issue_rd;
    logic [3:0]  issue_qj;
    logic [3:0]  issue_qk;
    logic [15:0] issue_vj;
    logic [15:0] issue_vk;
    logic        fu_valid;
    logic        fu_ready;
    logic        fu_op;
    logic [15:0] fu_a;
    logic [15:0] fu_b;
    logic [1:0]  fu_label;
    logic [2:0]  fu_rd;
    logic [3:0]  busy;

    int nCompared   = 0;
    int nMismatched = 0;

    reservation_station #(.UNIT(1'b0), .ENTRIES(4)) dut (
        .Clock(Clock),
        .Resetn(Resetn),
        .cdb(cdb),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_label(issue_label),
        .issue_op(issue_op),
        .issue_rd(issue_rd),
        .issue_qj(issue_qj),
        .issue_qk(issue_qk),
        .issue_vj(issue_vj),
        .issue_vk(issue_vk),
        .fu_valid(fu_valid),
        .fu_ready(fu_ready),
        .fu_op(fu_op),
        .fu_a(fu_a),
        .fu_b(fu_b),
        .fu_label(fu_label),
        .fu_rd(fu_rd),
        .busy(busy)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [23:0] mkCdb(input logic unit, input logic [1:0] label,
                                          input logic [15:0] data);
        return {1'b0, 1'b1, unit, label, 3'd0, data};
    endfunction

    task automatic doIssue(input logic op, input logic [2:0] rd,
                           input logic [3:0] qj, input logic [15:0] vj,
                           input logic [3:0] qk, input logic [15:0] vk);
        issue_op    = op;
        issue_rd    = rd;
        issue_qj    = qj;
        issue_vj    = vj;
        issue_qk    = qk;
        issue_vk    = vk;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic doReset();
        Resetn = 1'b0;
        tick();
        Resetn = 1'b1;
    endtask

    initial begin
        Resetn      = 1'b0;
        cdb         = 24'd0;
        issue_valid = 1'b0;
        issue_op    = 1'b0;
        issue_rd    = 3'd0;
        issue_qj    = 4'd0;
        issue_qk    = 4'd0;
        issue_vj    = 16'd0;
        issue_vk    = 16'd0;
        fu_ready    = 1'b0;

        tick();
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);
        chk("rst_issue_label", 32'(issue_label), 32'd0);
        chk("rst_fu_valid", 32'(fu_valid), 32'd0);
        chk("rst_fu_a", 32'(fu_a), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        Resetn = 1'b1;

        // Both operands ready at issue
        doIssue(1'b0, 3'd3, 4'b0000, 16'd5, 4'b0000, 16'd7);
        chk("add_fu_valid", 32'(fu_valid), 32'd1);
        chk("add_fu_a", 32'(fu_a), 32'd5);
        chk("add_fu_b", 32'(fu_b), 32'd7);
        chk("add_fu_label", 32'(fu_label), 32'd0);
        chk("add_fu_rd", 32'(fu_rd), 32'd3);
        chk("add_busy", 32'(busy), 32'b0001);
        fu_ready = 1'b1;
        tick();
        fu_ready = 1'b0;
        chk("exec_fu_valid", 32'(fu_valid), 32'd0);
        chk("exec_busy", 32'(busy), 32'b0001);
        cdb = mkCdb(1'b0, 2'b00, 16'h00AA);
        tick();
        cdb = 24'd0;
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_issue_ready", 32'(issue_ready), 32'd1);

        // Pending Qj resolved by snoop
        doIssue(1'b1, 3'd2, 4'b1101, 16'd0, 4'b0000, 16'd9);
        chk("wait_fu_valid", 32'(fu_valid), 32'd0);
        chk("wait_busy", 32'(busy), 32'b0001);
        cdb = mkCdb(1'b1, 2'b01, 16'h0042);
        tick();
        cdb = 24'd0;
        chk("snoop_fu_valid", 32'(fu_valid), 32'd1);
        chk("snoop_fu_a", 32'(fu_a), 32'h0042);
        chk("snoop_fu_b", 32'(fu_b), 32'd9);
        chk("snoop_fu_op", 32'(fu_op), 32'd1);
        chk("snoop_fu_rd", 32'(fu_rd), 32'd2);
        doReset();

        // Fill all four entries with the FU stalled
        for (int i = 0; i < 4; i++) begin
            chk("fill_label", 32'(issue_label), 32'(i));
            doIssue(1'b0, 3'(i), 4'b0000, 16'(10 + i), 4'b0000, 16'(20 + i));
        end
        chk("full_issue_ready", 32'(issue_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'b1111);
        chk("full_fu_a", 32'(fu_a), 32'd10);
        doIssue(1'b1, 3'd7, 4'b0000, 16'd99, 4'b0000, 16'd98);
        chk("fifth_busy", 32'(busy), 32'b1111);
        chk("hold_fu_a", 32'(fu_a), 32'd10);
        chk("hold_fu_b", 32'(fu_b), 32'd20);
        chk("hold_fu_label", 32'(fu_label), 32'd0);

        // Dispatch entries 0..2, then complete entry 2
        fu_ready = 1'b1;
        tick();
        chk("disp1_label", 32'(fu_label), 32'd1);
        tick();
        tick();
        fu_ready = 1'b0;
        chk("disp3_label", 32'(fu_label), 32'd3);
        chk("disp3_fu_a", 32'(fu_a), 32'd13);
        cdb = mkCdb(1'b0, 2'b10, 16'h0001);
        #1;
        chk("free_same_cycle_ready", 32'(issue_ready), 32'd0);
        doIssue(1'b0, 3'd1, 4'b0000, 16'd77, 4'b0000, 16'd78);
        chk("free_busy", 32'(busy), 32'b1011);
        chk("free_issue_ready", 32'(issue_ready), 32'd1);
        chk("free_issue_label", 32'(issue_label), 32'd2);
        cdb = mkCdb(1'b0, 2'b11, 16'h0002);
        tick();
        chk("ready_not_freed_busy", 32'(busy), 32'b1011);
        chk("ready_not_freed_fu", 32'(fu_label), 32'd3);
        cdb = mkCdb(1'b1, 2'b00, 16'h0003);
        tick();
        cdb = 24'd0;
        chk("wrong_unit_busy", 32'(busy), 32'b1011);
        doReset();

        // Both tags bypassed from the concurrent broadcast
        cdb = mkCdb(1'b0, 2'b10, 16'h1234);
        doIssue(1'b0, 3'd4, 4'b1010, 16'd0, 4'b1010, 16'd0);
        cdb = 24'd0;
        chk("bypass_fu_valid", 32'(fu_valid), 32'd1);
        chk("bypass_fu_a", 32'(fu_a), 32'h1234);
        chk("bypass_fu_b", 32'(fu_b), 32'h1234);
        chk("bypass_busy", 32'(busy), 32'b0001);
        doReset();

        // Qj and Qk cleared by the same snoop
        doIssue(1'b0, 3'd5, 4'b1110, 16'd0, 4'b1110, 16'd0);
        chk("dual_wait_fu_valid", 32'(fu_valid), 32'd0);
        cdb = mkCdb(1'b1, 2'b10, 16'h00BE);
        tick();
        cdb = 24'd0;
        chk("dual_fu_valid", 32'(fu_valid), 32'd1);
        chk("dual_fu_a", 32'(fu_a), 32'h00BE);
        chk("dual_fu_b", 32'(fu_b), 32'h00BE);
        doReset();

        // Reset during a matching broadcast discards waiting entries
        doIssue(1'b0, 3'd1, 4'b1101, 16'd0, 4'b0000, 16'd3);
        doIssue(1'b1, 3'd2, 4'b1110, 16'd0, 4'b1110, 16'd0);
        chk("pre_rst_busy", 32'(busy), 32'b0011);
        chk("pre_rst_fu_valid", 32'(fu_valid), 32'd0);
        Resetn = 1'b0;
        cdb = mkCdb(1'b1, 2'b01, 16'h5555);
        tick();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_fu_valid", 32'(fu_valid), 32'd0);
        chk("mid_rst_fu_a", 32'(fu_a), 32'd0);
        chk("mid_rst_issue_ready", 32'(issue_ready), 32'd1);
        chk("mid_rst_issue_label", 32'(issue_label), 32'd0);
        Resetn = 1'b1;
        tick();
        cdb = 24'd0;
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_fu_valid", 32'(fu_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
